// File: rtl/clkcfg_seq.sv
// clkcfg_seq: sequences core clock-config writes into altera_clock safely
module clkcfg_seq #(
    parameter int SETTLE_CYCLES = 1600000,
    parameter int RESET_CYCLES  = 16
) (
    input  logic       clock,
    input  logic       res,
    input  logic [7:0] cfg_req,
    input  logic       cfg_strobe,
    output logic [6:0] cfg_out,
    output logic       busy,
    output logic       done,
    output logic       soft_res
);
    localparam int CMAX = SETTLE_CYCLES > RESET_CYCLES ? SETTLE_CYCLES : RESET_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] RESET_END = CW'(RESET_CYCLES);

    typedef enum logic [2:0] {IDLE, SETTLE, SWITCH, FINAL, RESET} state_t;

    state_t        state;
    logic [7:0]    req;
    logic [7:0]    pend;
    logic          pend_v;
    logic [CW-1:0] cnt;

    // A queued request takes priority over a fresh strobe when leaving FINAL
    logic [7:0] nreq;
    logic       take;
    logic [1:0] en_new;
    logic       noop;
    assign nreq   = pend_v ? pend : cfg_req;
    assign take   = pend_v | cfg_strobe;
    assign en_new = nreq[6:5] & ~cfg_out[6:5];
    assign noop   = nreq[6:0] == cfg_out && !nreq[7];

    // Sequencer: enable sources, settle, switch CLKSEL, drop unused sources, optional soft reset
    always_ff @(posedge clock) begin
        if (res) begin
            state    <= IDLE;
            cfg_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            soft_res <= 1'b0;
            cnt      <= '0;
            req      <= '0;
            pend     <= '0;
            pend_v   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cfg_strobe) begin
                pend   <= cfg_req;
                pend_v <= pend_v | (state != IDLE);
            end
            case (state)
                IDLE: begin
                    pend_v <= pend_v & cfg_strobe;
                    if (take) begin
                        req <= nreq;
                        if (noop) begin
                            done <= 1'b1;
                        end else begin
                            cfg_out <= {cfg_out[6:5] | nreq[6:5], nreq[4:3], cfg_out[2:0]};
                            busy    <= 1'b1;
                            state   <= |en_new ? SETTLE : SWITCH;
                        end
                    end
                end
                SETTLE: begin
                    cnt   <= cnt == SETTLE_LAST ? '0 : cnt + 1'b1;
                    state <= cnt == SETTLE_LAST ? SWITCH : SETTLE;
                end
                SWITCH: begin
                    cfg_out <= {cfg_out[6:5] | req[6:5], req[4:0]};
                    state   <= FINAL;
                end
                FINAL: begin
                    cfg_out <= req[6:0];
                    done    <= 1'b1;
                    busy    <= req[7];
                    state   <= req[7] ? RESET : IDLE;
                end
                RESET: begin
                    if (cnt == RESET_END) begin
                        cnt      <= '0;
                        soft_res <= 1'b0;
                        busy     <= 1'b0;
                        pend_v   <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        soft_res <= 1'b1;
                        cnt      <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
